// File: rtl/time_alarm_set_ctrl.sv
// Button-driven time/alarm configuration sequencer: debounces buttons, walks the
// edit-field FSM, edits the selected field with wrap-around and strobes it back.
module time_alarm_set_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1000000000,
    parameter logic [25:0] BLINK_CYCLES    = 26'd25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    input  logic [7:0] alm_hour,
    input  logic [7:0] alm_min,
    input  logic [7:0] alm_sec,
    output logic [2:0] mode,
    output logic [7:0] edit_val,
    output logic       ld_t_hour,
    output logic       ld_t_min,
    output logic       ld_t_sec,
    output logic       ld_a_hour,
    output logic       ld_a_min,
    output logic       ld_a_sec,
    output logic       halt,
    output logic       blink
);

    localparam int unsigned DW = 20;
    localparam int unsigned TW = 32;
    localparam int unsigned BW = 26;
    localparam int unsigned VW = 8;
    localparam int unsigned NB = 3;

    typedef enum logic [2:0] {
        RUN    = 3'b000,
        T_HOUR = 3'b001,
        T_MIN  = 3'b010,
        T_SEC  = 3'b011,
        A_HOUR = 3'b100,
        A_MIN  = 3'b101,
        A_SEC  = 3'b110,
        BAD    = 3'b111
    } state_t;

    logic [NB-1:0] sync1, sync2, level, press;
    logic [DW-1:0] db_cnt [NB];

    // Per-button synchronizer, debounce and rising-edge press pulse ({mode, inc, dec})
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < int'(NB); i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_mode, btn_inc, btn_dec};
            sync2 <= sync1;
            for (int i = 0; i < int'(NB); i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic p_mode, p_inc, p_dec;
    assign p_mode = press[2];
    assign p_inc  = press[1];
    assign p_dec  = press[0];

    state_t        state, state_nxt, succ;
    logic          commit, commit_nxt;
    logic [VW-1:0] val_nxt, succ_val, fmax, stepped;
    logic [5:0]    ld_r, ld_nxt, ld_sel;
    logic          halt_nxt, blink_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;

    // Successor field, its source value and the strobe for the current field
    always_comb begin
        succ   = RUN;
        ld_sel = 6'b000000;
        case (state)
            RUN:     succ = T_HOUR;
            T_HOUR:  begin succ = T_MIN;  ld_sel = 6'b100000; end
            T_MIN:   begin succ = T_SEC;  ld_sel = 6'b010000; end
            T_SEC:   begin succ = A_HOUR; ld_sel = 6'b001000; end
            A_HOUR:  begin succ = A_MIN;  ld_sel = 6'b000100; end
            A_MIN:   begin succ = A_SEC;  ld_sel = 6'b000010; end
            A_SEC:   begin succ = RUN;    ld_sel = 6'b000001; end
            default: succ = RUN;
        endcase
    end

    always_comb begin
        succ_val = '0;
        case (succ)
            T_HOUR:  succ_val = cur_hour;
            T_MIN:   succ_val = cur_min;
            T_SEC:   succ_val = cur_sec;
            A_HOUR:  succ_val = alm_hour;
            A_MIN:   succ_val = alm_min;
            A_SEC:   succ_val = alm_sec;
            default: succ_val = '0;
        endcase
    end

    // Wrap-around step; an out-of-range value snaps to 0 on the first edit
    always_comb begin
        fmax    = (state == T_HOUR || state == A_HOUR) ? VW'(23) : VW'(59);
        stepped = edit_val;
        if (edit_val > fmax)  stepped = '0;
        else if (p_inc)       stepped = (edit_val == fmax) ? '0 : edit_val + VW'(1);
        else                  stepped = (edit_val == '0) ? fmax : edit_val - VW'(1);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state;
        commit_nxt    = 1'b0;
        val_nxt       = edit_val;
        ld_nxt        = '0;
        tmo_nxt       = tmo_cnt + TW'(1);
        blink_nxt     = blink;
        blink_cnt_nxt = blink_cnt + BW'(1);

        if (state == BAD) begin
            state_nxt = RUN;
            val_nxt   = '0;
        end else if (commit) begin
            state_nxt = succ;
            val_nxt   = succ_val;
        end else if (state == RUN) begin
            if (p_mode) begin
                state_nxt = succ;
                val_nxt   = succ_val;
            end
        end else if (p_mode) begin
            commit_nxt = 1'b1;
            ld_nxt     = ld_sel;
        end else if (tmo_cnt == TIMEOUT_CYCLES - 32'd1) begin
            state_nxt = RUN;
            val_nxt   = '0;
        end else if (p_inc ^ p_dec) begin
            val_nxt = stepped;
        end

        if (state_nxt == RUN || |press) tmo_nxt = '0;

        halt_nxt = (state_nxt == T_HOUR || state_nxt == T_MIN || state_nxt == T_SEC);

        if (state_nxt == RUN || state_nxt == BAD) begin
            blink_nxt     = 1'b0;
            blink_cnt_nxt = '0;
        end else if (state_nxt != state) begin
            blink_nxt     = 1'b1;
            blink_cnt_nxt = '0;
        end else if (blink_cnt == BLINK_CYCLES - 26'd1) begin
            blink_nxt     = ~blink;
            blink_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            commit    <= 1'b0;
            edit_val  <= '0;
            ld_r      <= '0;
            halt      <= 1'b0;
            blink     <= 1'b0;
            tmo_cnt   <= '0;
            blink_cnt <= '0;
        end else begin
            state     <= state_nxt;
            commit    <= commit_nxt;
            edit_val  <= val_nxt;
            ld_r      <= ld_nxt;
            halt      <= halt_nxt;
            blink     <= blink_nxt;
            tmo_cnt   <= tmo_nxt;
            blink_cnt <= blink_cnt_nxt;
        end
    end

    assign mode = state;
    assign {ld_t_hour, ld_t_min, ld_t_sec, ld_a_hour, ld_a_min, ld_a_sec} = ld_r;

endmodule

// File: tb/tb_time_alarm_set_ctrl.sv
// Table-driven bench for time_alarm_set_ctrl with hand-written sequences for
// debounce glitch, timeout and mid-edit reset.
module tb_time_alarm_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_inc, btn_dec;
    logic [7:0] cur_hour, cur_min, cur_sec, alm_hour, alm_min, alm_sec;
    logic [2:0] mode;
    logic [7:0] edit_val;
    logic       ld_t_hour, ld_t_min, ld_t_sec, ld_a_hour, ld_a_min, ld_a_sec;
    logic       halt, blink;

    time_alarm_set_ctrl #(
        .DEBOUNCE_CYCLES(20'd4),
        .TIMEOUT_CYCLES (32'd200),
        .BLINK_CYCLES   (26'd8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alm_hour(alm_hour), .alm_min(alm_min), .alm_sec(alm_sec),
        .mode(mode), .edit_val(edit_val),
        .ld_t_hour(ld_t_hour), .ld_t_min(ld_t_min), .ld_t_sec(ld_t_sec),
        .ld_a_hour(ld_a_hour), .ld_a_min(ld_a_min), .ld_a_sec(ld_a_sec),
        .halt(halt), .blink(blink)
    );

    always #5 clk = ~clk;

    logic [5:0] ld_bus;
    assign ld_bus = {ld_t_hour, ld_t_min, ld_t_sec, ld_a_hour, ld_a_min, ld_a_sec};

    // Strobe monitor: per-bit high-cycle counts and the value present at the strobe
    int         ld_bit_cnt [6];
    int         ld_multi = 0;
    logic [7:0] last_ld_val = '0;
    initial for (int j = 0; j < 6; j++) ld_bit_cnt[j] = 0;
    always @(negedge clk) begin
        if (|ld_bus) begin
            for (int j = 0; j < 6; j++) if (ld_bus[j]) ld_bit_cnt[j]++;
            last_ld_val = edit_val;
        end
        if ($countones(ld_bus) > 1) ld_multi++;
    end

    typedef struct {
        logic [2:0] btns;   // {mode, inc, dec}
        logic [2:0] mode;
        logic [7:0] val;
        logic       halt;
        logic [5:0] ld;     // {t_hour, t_min, t_sec, a_hour, a_min, a_sec}
        logic [7:0] ld_val;
    } vec_t;

    vec_t vecs [27];
    int   n_cmp = 0;
    int   n_err = 0;
    int   snap  [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic take_snap();
        for (int j = 0; j < 6; j++) snap[j] = ld_bit_cnt[j];
    endtask

    task automatic ld_delta(output logic [5:0] mask, output int cycles);
        mask   = '0;
        cycles = 0;
        for (int j = 0; j < 6; j++) begin
            cycles += ld_bit_cnt[j] - snap[j];
            if (ld_bit_cnt[j] != snap[j]) mask[j] = 1'b1;
        end
    endtask

    task automatic press(input logic [2:0] b);
        {btn_mode, btn_inc, btn_dec} = b;
        repeat (10) @(posedge clk);
        #1 {btn_mode, btn_inc, btn_dec} = 3'b000;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [5:0] mask;
        int         cyc;
        for (int i = lo; i <= hi; i++) begin
            take_snap();
            press(vecs[i].btns);
            ld_delta(mask, cyc);
            check($sformatf("v%0d_mode", i), 32'(mode), 32'(vecs[i].mode));
            check($sformatf("v%0d_val", i), 32'(edit_val), 32'(vecs[i].val));
            check($sformatf("v%0d_halt", i), 32'(halt), 32'(vecs[i].halt));
            check($sformatf("v%0d_ldmask", i), 32'(mask), 32'(vecs[i].ld));
            check($sformatf("v%0d_ldcycles", i), 32'(cyc), 32'($countones(vecs[i].ld)));
            if (vecs[i].ld != 6'b0)
                check($sformatf("v%0d_ldval", i), 32'(last_ld_val), 32'(vecs[i].ld_val));
            if (vecs[i].mode == 3'd0)
                check($sformatf("v%0d_blink_run", i), 32'(blink), 32'd0);
        end
    endtask

    initial begin
        logic [5:0] mask;
        int         cyc;
        logic       seen0, seen1, done;

        //           btns    mode  val    halt  ld         ld_val
        vecs[0]  = '{3'b100, 3'd1, 8'd22, 1'b1, 6'b000000, 8'd0};
        vecs[1]  = '{3'b010, 3'd1, 8'd23, 1'b1, 6'b000000, 8'd0};
        vecs[2]  = '{3'b010, 3'd1, 8'd0,  1'b1, 6'b000000, 8'd0};
        vecs[3]  = '{3'b010, 3'd1, 8'd1,  1'b1, 6'b000000, 8'd0};
        vecs[4]  = '{3'b100, 3'd2, 8'd0,  1'b1, 6'b100000, 8'd1};
        vecs[5]  = '{3'b001, 3'd2, 8'd59, 1'b1, 6'b000000, 8'd0};
        vecs[6]  = '{3'b100, 3'd3, 8'd30, 1'b1, 6'b010000, 8'd59};
        vecs[7]  = '{3'b010, 3'd3, 8'd31, 1'b1, 6'b000000, 8'd0};
        vecs[8]  = '{3'b100, 3'd4, 8'd6,  1'b0, 6'b001000, 8'd31};
        vecs[9]  = '{3'b001, 3'd4, 8'd5,  1'b0, 6'b000000, 8'd0};
        vecs[10] = '{3'b100, 3'd5, 8'd45, 1'b0, 6'b000100, 8'd5};
        vecs[11] = '{3'b100, 3'd6, 8'd59, 1'b0, 6'b000010, 8'd45};
        vecs[12] = '{3'b010, 3'd6, 8'd0,  1'b0, 6'b000000, 8'd0};
        vecs[13] = '{3'b001, 3'd6, 8'd59, 1'b0, 6'b000000, 8'd0};
        vecs[14] = '{3'b100, 3'd0, 8'd0,  1'b0, 6'b000001, 8'd59};
        vecs[15] = '{3'b010, 3'd0, 8'd0,  1'b0, 6'b000000, 8'd0};
        vecs[16] = '{3'b100, 3'd1, 8'd22, 1'b1, 6'b000000, 8'd0};
        vecs[17] = '{3'b011, 3'd1, 8'd22, 1'b1, 6'b000000, 8'd0};
        vecs[18] = '{3'b110, 3'd2, 8'd0,  1'b1, 6'b100000, 8'd22};
        vecs[19] = '{3'b100, 3'd3, 8'd30, 1'b1, 6'b010000, 8'd0};
        vecs[20] = '{3'b100, 3'd4, 8'd6,  1'b0, 6'b001000, 8'd30};
        vecs[21] = '{3'b100, 3'd5, 8'd45, 1'b0, 6'b000100, 8'd6};
        // Second pass with an out-of-range hour on the clock core
        vecs[22] = '{3'b100, 3'd1, 8'd30, 1'b1, 6'b000000, 8'd0};
        vecs[23] = '{3'b001, 3'd1, 8'd0,  1'b1, 6'b000000, 8'd0};
        vecs[24] = '{3'b100, 3'd2, 8'd0,  1'b1, 6'b100000, 8'd0};
        vecs[25] = '{3'b100, 3'd3, 8'd30, 1'b1, 6'b010000, 8'd0};
        vecs[26] = '{3'b010, 3'd3, 8'd31, 1'b1, 6'b000000, 8'd0};

        {btn_mode, btn_inc, btn_dec} = 3'b000;
        cur_hour = 8'd22; cur_min = 8'd0;  cur_sec = 8'd30;
        alm_hour = 8'd6;  alm_min = 8'd45; alm_sec = 8'd59;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_val", 32'(edit_val), 32'd0);
        check("rst_ld", 32'(ld_bus), 32'd0);
        check("rst_halt_blink", 32'({halt, blink}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Two-cycle glitch must not be accepted
        take_snap();
        btn_mode = 1'b1;
        repeat (2) @(posedge clk);
        #1 btn_mode = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        ld_delta(mask, cyc);
        check("glitch_mode", 32'(mode), 32'd0);
        check("glitch_ld", 32'(cyc), 32'd0);

        run_vecs(0, 21);

        // Idle in A_MIN: blink runs, then the edit is abandoned without a strobe
        seen0 = 1'b0;
        seen1 = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (blink) seen1 = 1'b1; else seen0 = 1'b0 | 1'b1;
        end
        check("blink_toggles", 32'({seen1, seen0}), 32'd3);
        take_snap();
        repeat (100) @(posedge clk);
        #1;
        check("pre_timeout_mode", 32'(mode), 32'd5);
        done = 1'b0;
        for (int k = 0; k < 150 && !done; k++) begin
            @(posedge clk);
            #1;
            if (mode == 3'd0) done = 1'b1;
        end
        check("timeout_reached", 32'(done), 32'd1);
        ld_delta(mask, cyc);
        check("timeout_ld", 32'(cyc), 32'd0);
        check("timeout_val", 32'(edit_val), 32'd0);
        check("timeout_blink", 32'(blink), 32'd0);
        check("timeout_halt", 32'(halt), 32'd0);

        cur_hour = 8'd30;
        run_vecs(22, 26);

        // Reset while editing T_SEC discards the edit
        take_snap();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_val", 32'(edit_val), 32'd0);
        check("midrst_halt", 32'(halt), 32'd0);
        check("midrst_blink", 32'(blink), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        ld_delta(mask, cyc);
        check("midrst_ld", 32'(cyc), 32'd0);
        check("midrst_mode_hold", 32'(mode), 32'd0);
        check("ld_onehot", 32'(ld_multi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
